// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arb_pkg
// Description : Shared types and constants for the 8-way round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    localparam logic [IDX_W-1:0] PTR_RESET = 3'd7;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage : arb_pkg
`default_nettype wire

// File: rtl/rr_prio_enc_8.sv
`default_nettype none
// ============================================================================
// Module      : rr_prio_enc_8
// Description : Combinational round-robin winner select: rotate, priority
//               encode (highest bit wins), un-rotate.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_prio_enc_8
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] win_idx,
    output logic             any_req
);

    logic [IDX_W-1:0]   w_shift;
    logic [2*N_REQ-1:0] w_dbl;
    logic [N_REQ-1:0]   w_rot;
    logic [IDX_W-1:0]   w_enc;

    // Rotating left by (7 - ptr) puts requester ptr at bit 7.
    assign w_shift = 3'd7 - ptr;
    assign w_dbl   = {req, req} << w_shift;
    assign w_rot   = w_dbl[2*N_REQ-1:N_REQ];

    always_comb begin
        w_enc = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_rot[i]) begin
                w_enc = IDX_W'(i);
            end
        end
    end

    assign win_idx = w_enc - w_shift;
    assign any_req = |req;

endmodule : rr_prio_enc_8
`default_nettype wire

// File: rtl/rr_arbiter_8.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_8
// Description : 8-requester round-robin arbiter with grant hold and
//               MAX_HOLD timeout; registered one-hot/index/valid outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_vld,
    output logic       timeout
);

    import arb_pkg::*;

    localparam logic [7:0] c_MAX_HOLD = 8'(MAX_HOLD);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [N_REQ-1:0] r_gnt,      w_gnt_nxt;
    logic [IDX_W-1:0] r_gnt_idx,  w_gnt_idx_nxt;
    logic             r_gnt_vld,  w_gnt_vld_nxt;
    logic             r_timeout,  w_timeout_nxt;
    logic [IDX_W-1:0] r_ptr,      w_ptr_nxt;
    logic [7:0]       r_hold_cnt, w_hold_cnt_nxt;

    logic [IDX_W-1:0] w_win;
    logic             w_any_req;
    logic             w_do_grant;
    logic             w_owner_req;

    rr_prio_enc_8 u_enc (
        .req     (req),
        .ptr     (r_ptr),
        .win_idx (w_win),
        .any_req (w_any_req)
    );

    assign w_owner_req = |(req & r_gnt);

    always_comb begin
        w_state_nxt    = r_state;
        w_gnt_nxt      = r_gnt;
        w_gnt_idx_nxt  = r_gnt_idx;
        w_gnt_vld_nxt  = r_gnt_vld;
        w_timeout_nxt  = 1'b0;
        w_ptr_nxt      = r_ptr;
        w_hold_cnt_nxt = r_hold_cnt;
        w_do_grant     = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_do_grant = 1'b1;
                end
            end
            GRANT: begin
                if (w_owner_req) begin
                    if (r_hold_cnt < c_MAX_HOLD) begin
                        w_hold_cnt_nxt = r_hold_cnt + 8'd1;
                    end else begin
                        // Owner already sits at lowest priority, so it only
                        // wins again when nobody else is asking.
                        w_timeout_nxt = 1'b1;
                        w_do_grant    = 1'b1;
                    end
                end else if (w_any_req) begin
                    w_do_grant = 1'b1;
                end else begin
                    w_state_nxt    = IDLE;
                    w_gnt_nxt      = '0;
                    w_gnt_idx_nxt  = '0;
                    w_gnt_vld_nxt  = 1'b0;
                    w_hold_cnt_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (w_do_grant) begin
            w_state_nxt    = GRANT;
            w_gnt_nxt      = N_REQ'(1) << w_win;
            w_gnt_idx_nxt  = w_win;
            w_gnt_vld_nxt  = 1'b1;
            w_hold_cnt_nxt = 8'd1;
            w_ptr_nxt      = w_win - 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_gnt      <= '0;
            r_gnt_idx  <= '0;
            r_gnt_vld  <= 1'b0;
            r_timeout  <= 1'b0;
            r_ptr      <= PTR_RESET;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_gnt_idx  <= w_gnt_idx_nxt;
            r_gnt_vld  <= w_gnt_vld_nxt;
            r_timeout  <= w_timeout_nxt;
            r_ptr      <= w_ptr_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
        end
    end

    assign gnt     = r_gnt;
    assign gnt_idx = r_gnt_idx;
    assign gnt_vld = r_gnt_vld;
    assign timeout = r_timeout;

endmodule : rr_arbiter_8
`default_nettype wire

// File: doc/rr_arbiter_8.md
Name: rr_arbiter_8

Overview:
- Grants one of 8 requesters access to a shared resource using round-robin priority.
- Ownership is held while the winner keeps its request asserted, bounded by a hold-timeout.
- Winner selection reuses the 8-to-3 priority-encoding scheme: a rotated request vector is encoded and the result is un-rotated.
- Sits between the 8 requesting blocks and the shared datapath. Outputs a one-hot grant, a binary index and a valid flag.

Parameters:
- MAX_HOLD, 16, maximum consecutive cycles one requester may hold the grant; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  8  request per requester; bit i = requester i
- gnt  output  8  one-hot grant, registered
- gnt_idx  output  3  binary index of the granted requester, registered
- gnt_vld  output  1  high while any grant is active, registered
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD expiry

Behaviour:
- Reset (asynchronous, rst_n=0):
  - gnt=8'h00, gnt_idx=3'd0, gnt_vld=0, timeout=0
  - ptr=3'd7, hold_cnt=0, state=IDLE
- Priority order: starts at ptr and descends modulo 8 (ptr, ptr-1, …, ptr+1). With ptr=7 this is plain fixed priority, bit 7 highest.
- Winner computation is combinational:
  - rotate req left by (7-ptr), so the bit at position ptr lands at bit 7
  - priority-encode (highest set bit wins)
  - un-rotate: w = (enc - (7-ptr)) mod 8
- Every grant to winner w:
  - gnt<=1<<w, gnt_idx<=w, gnt_vld<=1, hold_cnt<=1
  - ptr<=(w-1) mod 8, so w becomes lowest priority next time
- Latency: a request seen in IDLE at edge k shows as a grant after edge k (1 cycle).
- IDLE:
  - req==0: stay in IDLE, outputs 0.
  - otherwise: grant the winner, go to GRANT.
- GRANT, current owner c:
  - req[c]=1 and hold_cnt<MAX_HOLD: keep the grant; hold_cnt<=hold_cnt+1.
  - req[c]=0 (release):
    - if other requests are pending, grant the new winner in the same edge (no dead cycle);
    - else clear gnt/gnt_vld and go to IDLE.
  - req[c]=1 and hold_cnt==MAX_HOLD (expiry):
    - pulse timeout=1 for one cycle;
    - re-arbitrate over the full req vector. c has lowest priority, so another requester wins if one is pending; otherwise c is re-granted and hold_cnt<=1.
- Simultaneous events: a release and an expiry in the same cycle count as a release; no timeout pulse.
- hold_cnt width is 8 bits and must never wrap past MAX_HOLD.
- Requests that drop while not granted are simply ignored. There is no request latching.
- Reset mid-grant: all outputs clear immediately (asynchronous), ptr returns to 7.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt_vld == |gnt.
  - gnt_idx matches gnt whenever gnt_vld=1.

Decomposition:
- Shared package `arb_pkg`:
  - state enum {IDLE, GRANT}
  - N_REQ=8, IDX_W=3
  - PTR_RESET=3'd7
- Sub-module `rr_prio_enc_8`: takes req[7:0] and ptr[2:0], returns win_idx[2:0] and any_req. Contains the rotate / priority-encode / un-rotate logic and is purely combinational.
- Top level holds the FSM, ptr, hold_cnt and the output registers.

Test Plan:
- Reset release, then req=8'b1000_0001 → after 1 edge gnt=8'h80, gnt_idx=7, gnt_vld=1; after 7 drops, gnt=8'h01 on the very next edge.
- Round-robin fairness: req=8'hFF held, each owner drops req for one cycle after its grant → grant order 7,6,5,4,3,2,1,0,7.
- Timeout, MAX_HOLD=4: req=8'h28 held constant → gnt=8'h20 for 4 cycles, timeout pulse, then gnt=8'h08 for 4 cycles, timeout pulse, then 8'h20 again.
- Lone hog, MAX_HOLD=4: req=8'h04 held → timeout pulses every 4 cycles, gnt stays 8'h04, gnt_vld never drops.
- Release with no others pending: req=8'h10 for 3 cycles then 0 → gnt=8'h10 for 3 cycles, then gnt=0, gnt_vld=0, state IDLE.
- Asynchronous reset mid-grant: rst_n low between edges while gnt=8'h02 → outputs 0 immediately; after release, req=8'h82 → gnt=8'h80 (ptr back to 7).
